// File: rtl/rbcp_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rbcp_master
//
// Local RBCP initiator. Takes byte-burst read/write commands from on-chip
// logic and plays them onto the RBCP slave bus the same way SiTCP does:
// ACT held for the whole burst, one WE/RE strobe per byte, address stepping
// by one per byte, and every strobe waiting for ACK. A per-byte ACK timeout
// aborts the burst and flags o_err.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed after a strobe for ACK (1..65535)
//
// Ports
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready        command handshake
//   i_cmd_we, i_cmd_addr, i_cmd_len  burst direction, start address, bytes-1
//   i_wd_valid/o_wd_ready/i_wd_data  write byte stream (write bursts)
//   o_rd_valid/i_rd_ready/o_rd_data  read byte stream (read bursts)
//   o_busy, o_done, o_err          status: in progress, end pulse, timeout
//   o_rbcp_act/addr/we/wd/re       RBCP master-side signals
//   i_rbcp_rd, i_rbcp_ack          RBCP slave response
// ---------------------------------------------------------------------------
module rbcp_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_len,
    input  logic        i_wd_valid,
    output logic        o_wd_ready,
    input  logic [7:0]  i_wd_data,
    output logic        o_rd_valid,
    input  logic        i_rd_ready,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_rbcp_act,
    output logic [31:0] o_rbcp_addr,
    output logic        o_rbcp_we,
    output logic [7:0]  o_rbcp_wd,
    output logic        o_rbcp_re,
    input  logic [7:0]  i_rbcp_rd,
    input  logic        i_rbcp_ack
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREP     = 3'd1,
        STROBE   = 3'd2,
        WAIT_ACK = 3'd3,
        NEXT     = 3'd4,
        HOLD     = 3'd5
    } state_t;

    // The abort fires on the cycle the counter holds its last value, so an
    // ACK arriving in that same cycle still wins.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        cmd_we_q;
    logic [7:0]  remain_q;
    logic [15:0] tmo_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cmd_we_q    <= 1'b0;
            remain_q    <= 8'd0;
            tmo_cnt     <= 16'd0;
            o_cmd_ready <= 1'b1;
            o_wd_ready  <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_data   <= 8'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rbcp_act  <= 1'b0;
            o_rbcp_addr <= 32'd0;
            o_rbcp_we   <= 1'b0;
            o_rbcp_wd   <= 8'd0;
            o_rbcp_re   <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            o_done    <= 1'b0;
            o_rbcp_we <= 1'b0;
            o_rbcp_re <= 1'b0;

            // The read byte register drains independently of the FSM; a new
            // capture can only happen after PREP saw it empty.
            if (o_rd_valid && i_rd_ready) begin
                o_rd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_we_q    <= i_cmd_we;
                        remain_q    <= i_cmd_len;
                        o_rbcp_addr <= i_cmd_addr;
                        o_rbcp_act  <= 1'b1;
                        o_err       <= 1'b0;
                        o_busy      <= 1'b1;
                        o_cmd_ready <= 1'b0;
                        o_wd_ready  <= i_cmd_we;
                        state       <= PREP;
                    end
                end

                PREP: begin
                    if (cmd_we_q) begin
                        if (i_wd_valid) begin
                            o_rbcp_wd  <= i_wd_data;
                            o_wd_ready <= 1'b0;
                            o_rbcp_we  <= 1'b1;
                            state      <= STROBE;
                        end
                    end else if (!o_rd_valid) begin
                        // Only strobe a read once the previous byte is gone,
                        // so the single-byte read register never overflows.
                        o_rbcp_re <= 1'b1;
                        state     <= STROBE;
                    end
                end

                STROBE: begin
                    tmo_cnt <= 16'd0;
                    state   <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (i_rbcp_ack) begin
                        if (!cmd_we_q) begin
                            o_rd_data  <= i_rbcp_rd;
                            o_rd_valid <= 1'b1;
                        end
                        state <= (remain_q == 8'd0) ? HOLD : NEXT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort: drop ACT immediately, skip remaining bytes.
                        o_rbcp_act  <= 1'b0;
                        o_err       <= 1'b1;
                        o_done      <= 1'b1;
                        o_busy      <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                NEXT: begin
                    o_rbcp_addr <= o_rbcp_addr + 32'd1;
                    remain_q    <= remain_q - 8'd1;
                    o_wd_ready  <= cmd_we_q;
                    state       <= PREP;
                end

                HOLD: begin
                    o_rbcp_act  <= 1'b0;
                    o_done      <= 1'b1;
                    o_busy      <= 1'b0;
                    o_cmd_ready <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbcp_master.sv
`timescale 1ns/1ps
// Testbench for rbcp_master: directed bursts, a behavioural RBCP slave and a
// scoreboard monitor that checks strobes, read bytes and completion status.
module tb_rbcp_master;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [7:0]  wd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        rbcp_act;
    logic [31:0] rbcp_addr;
    logic        rbcp_we;
    logic [7:0]  rbcp_wd;
    logic        rbcp_re;
    logic [7:0]  rbcp_rd;
    logic        rbcp_ack;

    rbcp_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_len   (cmd_len),
        .i_wd_valid  (wd_valid),
        .o_wd_ready  (wd_ready),
        .i_wd_data   (wd_data),
        .o_rd_valid  (rd_valid),
        .i_rd_ready  (rd_ready),
        .o_rd_data   (rd_data),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_rbcp_act  (rbcp_act),
        .o_rbcp_addr (rbcp_addr),
        .o_rbcp_we   (rbcp_we),
        .o_rbcp_wd   (rbcp_wd),
        .o_rbcp_re   (rbcp_re),
        .i_rbcp_rd   (rbcp_rd),
        .i_rbcp_ack  (rbcp_ack)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wd;
    } strb_t;

    strb_t      exp_strb[$];
    logic [7:0] exp_rd[$];
    logic       exp_done[$];
    logic [7:0] slv_rd_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int last_strobe_cyc = 0;
    int last_ack_cyc = 0;
    int ack_delay = 2;
    bit mon_en = 0;
    bit in_burst = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic exp_s(input logic we, input logic [31:0] a, input logic [7:0] d);
        strb_t s;
        s.we = we;
        s.addr = a;
        s.wd = d;
        exp_strb.push_back(s);
    endtask

    // Behavioural RBCP slave: ACK (and read data) ack_delay cycles after a strobe.
    initial begin
        logic [7:0] d;
        rbcp_ack = 1'b0;
        rbcp_rd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && (rbcp_we || rbcp_re) && ack_delay >= 0) begin
                d = 8'hEE;
                if (rbcp_re && slv_rd_q.size() > 0) d = slv_rd_q.pop_front();
                repeat (ack_delay) @(posedge clk);
                #1;
                rbcp_ack = 1'b1;
                rbcp_rd = d;
                last_ack_cyc = cyc;
                @(posedge clk);
                #1;
                rbcp_ack = 1'b0;
                rbcp_rd = 8'h00;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        strb_t e;
        logic [7:0] r;
        logic x;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (rbcp_we || rbcp_re) begin
                    strobe_cnt++;
                    last_strobe_cyc = cyc;
                    if (exp_strb.size() == 0) begin
                        fail("strobe_unexpected", $sformatf("got we=%0b re=%0b addr=0x%0h, required none", rbcp_we, rbcp_re, rbcp_addr));
                    end else begin
                        e = exp_strb.pop_front();
                        chk("strobe_we", rbcp_we, e.we);
                        chk("strobe_re", rbcp_re, !e.we);
                        chk("strobe_addr", rbcp_addr, e.addr);
                        if (e.we) chk("strobe_wd", rbcp_wd, e.wd);
                        else chk("re_with_rd_empty", rd_valid, 0);
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        fail("rd_unexpected", $sformatf("got byte 0x%0h, required none", rd_data));
                    end else begin
                        r = exp_rd.pop_front();
                        chk("rd_data", rd_data, r);
                    end
                end
                if (done) begin
                    in_burst = 0;
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        fail("done_unexpected", "got o_done=1, required 0");
                    end else begin
                        x = exp_done.pop_front();
                        chk("done_err", err, x);
                        if (x) chk("abort_latency", cyc - last_strobe_cyc, TMO + 1);
                        else chk("done_latency", cyc - last_ack_cyc, 2);
                    end
                end
                chk("act", rbcp_act, in_burst);
                chk("busy", busy, in_burst);
                chk("cmd_ready", cmd_ready, !in_burst);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [7:0] len);
        int n;
        logic hs;
        n = 0;
        hs = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_addr = a;
        cmd_len = len;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!hs) fail("cmd_accept", "got no accept, required accept within 50 cycles");
        else in_burst = 1;
    endtask

    task automatic send_wd(input logic [7:0] d, input int gap);
        int n;
        logic hs;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        wd_valid = 1'b1;
        wd_data = d;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = wd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        wd_valid = 1'b0;
        if (!hs) fail("wd_accept", "got no write-byte accept, required accept within 100 cycles");
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt == start) fail("done_wait", "got no o_done, required one within budget");
    endtask

    initial begin
        int s0;
        int d0;
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = 32'h0;
        cmd_len = 8'h0;
        wd_valid = 1'b0;
        wd_data = 8'h0;
        rd_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_ctrl", {rbcp_act, busy, done, err, wd_ready, rd_valid, rbcp_we, rbcp_re}, 8'h00);
        chk("reset_data", {rbcp_addr, rbcp_wd, rd_data}, 48'h0);
        mon_en = 1;
        @(posedge clk);
        #1;

        // Single write, ACK two cycles after WE.
        ack_delay = 2;
        s0 = strobe_cnt;
        exp_s(1'b1, 32'h0000_0010, 8'hA5);
        exp_done.push_back(1'b0);
        issue(1'b1, 32'h0000_0010, 8'd0);
        send_wd(8'hA5, 0);
        wait_done(50);
        chk("single_write_we_count", strobe_cnt - s0, 1);

        // Four-byte read.
        ack_delay = 3;
        s0 = strobe_cnt;
        slv_rd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) exp_s(1'b0, 32'h0002_0000 + 32'(i), 8'h00);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        exp_rd.push_back(8'h44);
        exp_done.push_back(1'b0);
        issue(1'b0, 32'h0002_0000, 8'd3);
        wait_done(200);
        chk("read4_re_count", strobe_cnt - s0, 4);

        // Read with back-pressure: byte 1 must not be strobed before byte 0 leaves.
        ack_delay = 2;
        rd_ready = 1'b0;
        s0 = strobe_cnt;
        slv_rd_q = '{8'h66, 8'h77};
        exp_s(1'b0, 32'h0000_0300, 8'h00);
        exp_s(1'b0, 32'h0000_0301, 8'h00);
        exp_rd.push_back(8'h66);
        exp_rd.push_back(8'h77);
        exp_done.push_back(1'b0);
        issue(1'b0, 32'h0000_0300, 8'd1);
        n = 0;
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rd_valid) fail("bp_rd_valid", "got o_rd_valid=0, required 1 within 50 cycles");
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_no_re_while_full", strobe_cnt - s0, 1);
        chk("bp_byte0_held", {rd_valid, rd_data}, {1'b1, 8'h66});
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        wait_done(100);

        // Write burst of three bytes with gaps on the write-byte stream.
        ack_delay = 1;
        s0 = strobe_cnt;
        exp_s(1'b1, 32'h0000_0040, 8'h01);
        exp_s(1'b1, 32'h0000_0041, 8'h02);
        exp_s(1'b1, 32'h0000_0042, 8'h03);
        exp_done.push_back(1'b0);
        issue(1'b1, 32'h0000_0040, 8'd2);
        send_wd(8'h01, 3);
        send_wd(8'h02, 0);
        send_wd(8'h03, 2);
        wait_done(100);
        chk("gap_write_we_count", strobe_cnt - s0, 3);

        // Timeout: no ACK, two-byte burst aborts after the first strobe.
        ack_delay = -1;
        s0 = strobe_cnt;
        exp_s(1'b1, 32'h0000_0050, 8'hBB);
        exp_done.push_back(1'b1);
        issue(1'b1, 32'h0000_0050, 8'd1);
        send_wd(8'hBB, 0);
        wait_done(50);
        @(negedge clk);
        chk("abort_err_held", err, 1);
        chk("abort_one_strobe", strobe_cnt - s0, 1);
        @(posedge clk);
        #1;

        // ACK on the last allowed cycle is a success; accept clears o_err.
        ack_delay = TMO;
        exp_s(1'b1, 32'h0000_0060, 8'hCC);
        exp_done.push_back(1'b0);
        issue(1'b1, 32'h0000_0060, 8'd0);
        @(negedge clk);
        chk("err_cleared_on_accept", err, 0);
        @(posedge clk);
        #1;
        send_wd(8'hCC, 0);
        wait_done(50);

        // Address wrap.
        ack_delay = 2;
        exp_s(1'b1, 32'hFFFF_FFFF, 8'h5A);
        exp_s(1'b1, 32'h0000_0000, 8'hC3);
        exp_done.push_back(1'b0);
        issue(1'b1, 32'hFFFF_FFFF, 8'd1);
        send_wd(8'h5A, 0);
        send_wd(8'hC3, 0);
        wait_done(100);

        // Reset in the middle of WAIT_ACK.
        ack_delay = -1;
        exp_s(1'b1, 32'h0000_0070, 8'h99);
        issue(1'b1, 32'h0000_0070, 8'd0);
        send_wd(8'h99, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_burst = 0;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_ctrl", {rbcp_act, busy, done, err, wd_ready, rd_valid, rbcp_we, rbcp_re}, 8'h00);
        chk("midrst_data", {rbcp_addr, rbcp_wd, rd_data}, 48'h0);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);

        chk("left_strobes", exp_strb.size(), 0);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_done", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
